// File: rtl/global_def.sv
// Shared definitions for the CP0 / exception responder.
// Holds CP0 register addresses, ExcCode values, the responder state encoding
// and the Status/Cause field bit positions.
package global_def;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } exc_state_e;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;

endpackage

// File: rtl/cp0_int_sync.sv
// Two-flop synchroniser for the external interrupt lines.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   async_i - interrupt lines, asynchronous to clk
//   sync_o  - lines after two flops (2-cycle latency)
module cp0_int_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 register file and exception/interrupt responder.
// Evaluates interrupt / unimplemented / syscall / eret for the WB instruction,
// keeps Status, Cause, EPC and PRId, and issues a one-cycle registered
// flush + redirect to the pipeline.
//
// State table
//   state    | meaning
//   ST_RUN   | normal operation, WB events and MTC0 are evaluated
//   ST_REDIR | redirect cycle, WB instruction is being flushed and ignored
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   HWInt               - external interrupt lines (asynchronous)
//   ValidWB, PCWB       - WB instruction valid flag and PC
//   UnimplWB/SysWB/EretWB - WB exception / eret flags
//   CPWr/CPWAddr/CPWData - MTC0 write port
//   CPRAddr/CPRData     - MFC0 read port (combinational)
//   ExcFlush/ExcRedirect/ExcPC - registered redirect to the pipeline
//   EPCOut              - current EPC
//   IntReq              - qualified interrupt pending
module cp0_exc_unit
  import global_def::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter logic [31:0] PRID_VAL   = 32'h0000_0001,
  parameter int          NUM_HWINT  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 ValidWB,
  input  logic [31:0]          PCWB,
  input  logic                 UnimplWB,
  input  logic                 SysWB,
  input  logic                 EretWB,
  input  logic                 CPWr,
  input  logic [4:0]           CPWAddr,
  input  logic [31:0]          CPWData,
  input  logic [4:0]           CPRAddr,
  output logic [31:0]          CPRData,
  output logic                 ExcFlush,
  output logic                 ExcRedirect,
  output logic [31:0]          ExcPC,
  output logic [31:0]          EPCOut,
  output logic                 IntReq
);

  logic [NUM_HWINT-1:0] ip;

  exc_state_e           state_q, state_d;
  logic [NUM_HWINT-1:0] im_q, im_d;
  logic                 exl_q, exl_d;
  logic                 ie_q, ie_d;
  logic [4:0]           exc_code_q, exc_code_d;
  logic [31:0]          epc_q, epc_d;
  logic                 flush_q, flush_d;
  logic                 redir_q, redir_d;
  logic [31:0]          exc_pc_q, exc_pc_d;

  logic                 int_req;
  logic                 eval;
  logic                 do_wr;
  logic                 take;
  logic [31:0]          target;

  cp0_int_sync #(.W(NUM_HWINT)) u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (HWInt),
    .sync_o  (ip)
  );

  assign int_req = ie_q & ~exl_q & (|(ip & im_q));
  assign eval    = (state_q == ST_RUN) & ValidWB;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    exc_pc_d   = exc_pc_q;
    flush_d    = 1'b0;
    redir_d    = 1'b0;
    state_d    = ST_RUN;
    take       = 1'b0;
    target     = EXC_VECTOR;

    // The WB instruction commits its MTC0 when an interrupt is taken or when
    // no other event fires; exceptions and eret drop it.
    do_wr = eval & CPWr & (int_req | ~(UnimplWB | SysWB | EretWB));

    if (do_wr) begin
      case (CPWAddr)
        CP0_SR: begin
          im_d  = CPWData[SR_IM_HI:SR_IM_LO];
          exl_d = CPWData[SR_EXL];
          ie_d  = CPWData[SR_IE];
        end
        CP0_EPC: epc_d = CPWData;
        default: ;
      endcase
    end

    // Event updates are applied after the MTC0 write so they override it.
    if (eval) begin
      if (int_req) begin
        take       = 1'b1;
        epc_d      = PCWB + 32'd4;
        exc_code_d = EXC_INT;
        exl_d      = 1'b1;
      end else if (UnimplWB) begin
        take       = 1'b1;
        epc_d      = PCWB;
        exc_code_d = EXC_RI;
        exl_d      = 1'b1;
      end else if (SysWB) begin
        take       = 1'b1;
        epc_d      = PCWB;
        exc_code_d = EXC_SYS;
        exl_d      = 1'b1;
      end else if (EretWB) begin
        take       = 1'b1;
        exl_d      = 1'b0;
        target     = epc_q;
      end
    end

    if (take) begin
      state_d  = ST_REDIR;
      flush_d  = 1'b1;
      redir_d  = 1'b1;
      exc_pc_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      exc_code_q <= EXC_INT;
      epc_q      <= '0;
      flush_q    <= 1'b0;
      redir_q    <= 1'b0;
      exc_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      flush_q    <= flush_d;
      redir_q    <= redir_d;
      exc_pc_q   <= exc_pc_d;
    end
  end

  always_comb begin
    CPRData = '0;
    case (CPRAddr)
      CP0_SR: begin
        CPRData[SR_IM_HI:SR_IM_LO] = im_q;
        CPRData[SR_EXL]            = exl_q;
        CPRData[SR_IE]             = ie_q;
      end
      CP0_CAUSE: begin
        CPRData[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        CPRData[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_q;
      end
      CP0_EPC:  CPRData = epc_q;
      CP0_PRID: CPRData = PRID_VAL;
      default:  CPRData = '0;
    endcase
  end

  // Only the SR fields and EPC are writable; the remaining data bits are dropped.
  logic unused_wdata;
  assign unused_wdata = ^{CPWData[31:16], CPWData[9:2]};

  assign ExcFlush    = flush_q;
  assign ExcRedirect = redir_q;
  assign ExcPC       = exc_pc_q;
  assign EPCOut      = epc_q;
  assign IntReq      = int_req;

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  HWInt;
  logic        ValidWB;
  logic [31:0] PCWB;
  logic        UnimplWB;
  logic        SysWB;
  logic        EretWB;
  logic        CPWr;
  logic [4:0]  CPWAddr;
  logic [31:0] CPWData;
  logic [4:0]  CPRAddr;
  logic [31:0] CPRData;
  logic        ExcFlush;
  logic        ExcRedirect;
  logic [31:0] ExcPC;
  logic [31:0] EPCOut;
  logic        IntReq;

  int n_cmp;
  int n_bad;

  cp0_exc_unit dut (
    .clk         (clk),
    .rst         (rst),
    .HWInt       (HWInt),
    .ValidWB     (ValidWB),
    .PCWB        (PCWB),
    .UnimplWB    (UnimplWB),
    .SysWB       (SysWB),
    .EretWB      (EretWB),
    .CPWr        (CPWr),
    .CPWAddr     (CPWAddr),
    .CPWData     (CPWData),
    .CPRAddr     (CPRAddr),
    .CPRData     (CPRData),
    .ExcFlush    (ExcFlush),
    .ExcRedirect (ExcRedirect),
    .ExcPC       (ExcPC),
    .EPCOut      (EPCOut),
    .IntReq      (IntReq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ValidWB  = 1'b0;
    PCWB     = '0;
    UnimplWB = 1'b0;
    SysWB    = 1'b0;
    EretWB   = 1'b0;
    CPWr     = 1'b0;
    CPWAddr  = '0;
    CPWData  = '0;
  endtask

  task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
    CPRAddr = addr;
    #1;
    chk(tag, CPRData, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    clr();
    ValidWB = 1'b1;
    PCWB    = 32'h0000_2000;
    CPWr    = 1'b1;
    CPWAddr = addr;
    CPWData = data;
    tick();
    clr();
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    HWInt   = '0;
    CPRAddr = '0;
    clr();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_flush", {31'b0, ExcFlush}, 32'h0);
    chk("rst_redir", {31'b0, ExcRedirect}, 32'h0);
    chk("rst_excpc", ExcPC, 32'h0);
    chk("rst_intreq", {31'b0, IntReq}, 32'h0);
    chk("rst_epc", EPCOut, 32'h0);
    rd(5'd12, "rst_sr", 32'h0);

    // register access
    mtc0(5'd12, 32'h0000_FC01);
    chk("mtc0_noflush", {31'b0, ExcFlush}, 32'h0);
    rd(5'd12, "sr_fc01", 32'h0000_FC01);
    rd(5'd13, "cause_0", 32'h0);
    rd(5'd14, "epc_0", 32'h0);
    rd(5'd15, "prid", 32'h0000_0001);
    rd(5'd20, "unmapped", 32'h0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_ro", 32'h0);

    // unimplemented instruction, with a dropped MTC0 to EPC
    ValidWB  = 1'b1;
    PCWB     = 32'h0000_3010;
    UnimplWB = 1'b1;
    CPWr     = 1'b1;
    CPWAddr  = 5'd14;
    CPWData  = 32'hDEAD_BEEF;
    tick();
    clr();
    chk("ri_flush", {31'b0, ExcFlush}, 32'h1);
    chk("ri_redir", {31'b0, ExcRedirect}, 32'h1);
    chk("ri_excpc", ExcPC, 32'h0000_0180);
    chk("ri_epc", EPCOut, 32'h0000_3010);
    rd(5'd13, "ri_cause", 32'h0000_0028);
    rd(5'd12, "ri_sr", 32'h0000_FC03);
    tick();
    chk("ri_pulse_flush", {31'b0, ExcFlush}, 32'h0);
    chk("ri_pulse_redir", {31'b0, ExcRedirect}, 32'h0);
    chk("ri_pc_hold", ExcPC, 32'h0000_0180);

    // interrupt
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, "sr_0401", 32'h0000_0401);
    HWInt = 6'b000001;
    tick();
    chk("int_sync1", {31'b0, IntReq}, 32'h0);
    tick();
    chk("int_sync2", {31'b0, IntReq}, 32'h1);
    rd(5'd13, "int_ip", 32'h0000_0428);
    tick();
    chk("int_wait_invalid", {31'b0, ExcRedirect}, 32'h0);
    ValidWB = 1'b1;
    PCWB    = 32'h0000_3020;
    tick();
    clr();
    chk("int_redir", {31'b0, ExcRedirect}, 32'h1);
    chk("int_excpc", ExcPC, 32'h0000_0180);
    chk("int_epc", EPCOut, 32'h0000_3024);
    chk("int_masked", {31'b0, IntReq}, 32'h0);
    rd(5'd13, "int_cause", 32'h0000_0400);
    rd(5'd12, "int_sr", 32'h0000_0403);
    tick();
    ValidWB = 1'b1;
    PCWB    = 32'h0000_3030;
    tick();
    chk("int_no_second", {31'b0, ExcRedirect}, 32'h0);

    // eret with the interrupt still pending
    EretWB = 1'b1;
    tick();
    clr();
    chk("eret_redir", {31'b0, ExcRedirect}, 32'h1);
    chk("eret_excpc", ExcPC, 32'h0000_3024);
    rd(5'd12, "eret_sr", 32'h0000_0401);
    chk("eret_intreq", {31'b0, IntReq}, 32'h1);

    // event during REDIR is ignored
    ValidWB = 1'b1;
    SysWB   = 1'b1;
    PCWB    = 32'h0000_3040;
    tick();
    clr();
    chk("redir_ign_redir", {31'b0, ExcRedirect}, 32'h0);
    chk("redir_ign_epc", EPCOut, 32'h0000_3024);
    rd(5'd13, "redir_ign_cause", 32'h0000_0400);

    // pending interrupt taken at next valid WB
    ValidWB = 1'b1;
    PCWB    = 32'h0000_3050;
    tick();
    clr();
    HWInt = '0;
    chk("int2_redir", {31'b0, ExcRedirect}, 32'h1);
    chk("int2_epc", EPCOut, 32'h0000_3054);
    tick();
    mtc0(5'd12, 32'h0);

    // syscall with a dropped MTC0 to EPC
    ValidWB = 1'b1;
    SysWB   = 1'b1;
    PCWB    = 32'h0000_3040;
    CPWr    = 1'b1;
    CPWAddr = 5'd14;
    CPWData = 32'h0000_1234;
    tick();
    clr();
    chk("sys_redir", {31'b0, ExcRedirect}, 32'h1);
    chk("sys_excpc", ExcPC, 32'h0000_0180);
    chk("sys_epc", EPCOut, 32'h0000_3040);
    rd(5'd13, "sys_cause", 32'h0000_0020);
    rd(5'd12, "sys_sr", 32'h0000_0002);
    tick();

    // unimpl and syscall together: unimpl wins
    ValidWB  = 1'b1;
    UnimplWB = 1'b1;
    SysWB    = 1'b1;
    PCWB     = 32'h0000_3060;
    tick();
    clr();
    chk("both_redir", {31'b0, ExcRedirect}, 32'h1);
    chk("both_epc", EPCOut, 32'h0000_3060);
    rd(5'd13, "both_cause", 32'h0000_0028);

    // reset during REDIR
    rst     = 1'b1;
    ValidWB = 1'b1;
    SysWB   = 1'b1;
    PCWB    = 32'h0000_3070;
    tick();
    clr();
    rst = 1'b0;
    chk("rstr_flush", {31'b0, ExcFlush}, 32'h0);
    chk("rstr_redir", {31'b0, ExcRedirect}, 32'h0);
    chk("rstr_excpc", ExcPC, 32'h0);
    chk("rstr_epc", EPCOut, 32'h0);
    chk("rstr_intreq", {31'b0, IntReq}, 32'h0);
    rd(5'd12, "rstr_sr", 32'h0);

    // eret with EXL=0 still redirects to EPC
    mtc0(5'd14, 32'h0000_5000);
    rd(5'd14, "epc_wr", 32'h0000_5000);
    ValidWB = 1'b1;
    EretWB  = 1'b1;
    PCWB    = 32'h0000_3080;
    tick();
    clr();
    chk("eret0_flush", {31'b0, ExcFlush}, 32'h1);
    chk("eret0_excpc", ExcPC, 32'h0000_5000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
